// File: rtl/ysyx_22050133_axi_master_bridge.sv
// Cache-side burst request bus to AXI4 master (AW/W/B/AR/R), one transaction at a time.
// Latency: request->AW/AR valid 1 cycle; W and R beats are combinational pass-through.
// Backpressure: request ready only in IDLE; beat readies/valids mirror the other side inside W/R.
module ysyx_22050133_axi_master_bridge #(
  parameter int RW_ADDR_WIDTH = 64,
  parameter int RW_DATA_WIDTH = 64,
  parameter int ID_WIDTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  // cache request
  input  logic                       rw_addr_valid_i,
  output logic                       rw_addr_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0]   rw_addr_i,
  input  logic                       rw_we_i,
  input  logic                       rw_if_i,
  input  logic [7:0]                 rw_len_i,
  input  logic [2:0]                 rw_size_i,
  input  logic [1:0]                 rw_burst_i,
  input  logic                       w_data_valid_i,
  output logic                       w_data_ready_o,
  input  logic [RW_DATA_WIDTH-1:0]   w_data_i,
  output logic                       r_data_valid_o,
  input  logic                       r_data_ready_i,
  output logic [RW_DATA_WIDTH-1:0]   r_data_o,
  output logic                       rw_err_o,
  // AXI AW
  output logic                       aw_valid_o,
  input  logic                       aw_ready_i,
  output logic [RW_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [ID_WIDTH-1:0]        aw_id_o,
  output logic [7:0]                 aw_len_o,
  output logic [2:0]                 aw_size_o,
  output logic [1:0]                 aw_burst_o,
  // AXI W
  output logic                       w_valid_o,
  input  logic                       w_ready_i,
  output logic [RW_DATA_WIDTH-1:0]   w_data_o,
  output logic [RW_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                       w_last_o,
  // AXI B
  input  logic                       b_valid_i,
  output logic                       b_ready_o,
  input  logic [1:0]                 b_resp_i,
  // AXI AR
  output logic                       ar_valid_o,
  input  logic                       ar_ready_i,
  output logic [RW_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [ID_WIDTH-1:0]        ar_id_o,
  output logic [7:0]                 ar_len_o,
  output logic [2:0]                 ar_size_o,
  output logic [1:0]                 ar_burst_o,
  // AXI R
  input  logic                       r_valid_i,
  output logic                       r_ready_o,
  input  logic [RW_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                 r_resp_i,
  input  logic                       r_last_i
);

  localparam int STRB_W = RW_DATA_WIDTH / 8;
  localparam int OFS_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [RW_ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]                 r_len;
  logic [7:0]                 r_cnt;
  logic [2:0]                 r_size;
  logic [1:0]                 r_burst;
  logic                       r_if;
  logic                       r_err;
  logic                       r_err_pulse;

  logic                       w_req_hs;
  logic                       w_w_hs;
  logic                       w_r_hs;
  logic                       w_b_hs;
  logic                       w_r_beat_err;
  logic [STRB_W-1:0]          w_size_mask;
  logic [STRB_W-1:0]          w_strb;
  int                         w_nbytes;

  assign w_req_hs     = (r_state == S_IDLE) & rw_addr_valid_i;
  assign w_w_hs       = (r_state == S_W) & w_data_valid_i & w_ready_i;
  assign w_r_hs       = (r_state == S_R) & r_valid_i & r_data_ready_i;
  assign w_b_hs       = (r_state == S_B) & b_valid_i;
  // A beat is bad if the slave flags it or rlast disagrees with our own beat count.
  assign w_r_beat_err = (r_resp_i != 2'b00) | (r_last_i ^ (r_cnt == 8'd0));

  // Address-channel fields come straight from the latched request.
  assign aw_addr_o  = r_addr;
  assign aw_id_o    = '0;
  assign aw_len_o   = r_len;
  assign aw_size_o  = r_size;
  assign aw_burst_o = r_burst;
  assign ar_addr_o  = r_addr;
  assign ar_id_o    = {{(ID_WIDTH-1){1'b0}}, r_if};
  assign ar_len_o   = r_len;
  assign ar_size_o  = r_size;
  assign ar_burst_o = r_burst;
  assign rw_err_o   = r_err_pulse;

  // Single-beat strobe covers 2**size bytes at the address offset; bursts write full beats.
  always_comb begin
    w_size_mask = '0;
    w_nbytes    = 1 << r_size;
    for (int b = 0; b < STRB_W; b++) begin
      w_size_mask[b] = (b < w_nbytes);
    end
    w_strb = (r_len == 8'd0) ? (w_size_mask << r_addr[OFS_W-1:0]) : '1;
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs; beat paths are gated to zero outside W/R.
  always_comb begin
    w_next          = r_state;
    rw_addr_ready_o = 1'b0;
    aw_valid_o      = 1'b0;
    ar_valid_o      = 1'b0;
    w_valid_o       = 1'b0;
    w_data_ready_o  = 1'b0;
    w_data_o        = '0;
    w_strb_o        = '0;
    w_last_o        = 1'b0;
    b_ready_o       = 1'b0;
    r_data_valid_o  = 1'b0;
    r_ready_o       = 1'b0;
    r_data_o        = '0;
    case (r_state)
      S_IDLE: begin
        rw_addr_ready_o = 1'b1;
        if (rw_addr_valid_i) w_next = rw_we_i ? S_AW : S_AR;
      end
      S_AR: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) w_next = S_R;
      end
      S_R: begin
        r_data_valid_o = r_valid_i;
        r_ready_o      = r_data_ready_i;
        r_data_o       = r_data_i;
        if (w_r_hs && r_last_i) w_next = S_IDLE;
      end
      S_AW: begin
        aw_valid_o = 1'b1;
        if (aw_ready_i) w_next = S_W;
      end
      S_W: begin
        w_valid_o      = w_data_valid_i;
        w_data_ready_o = w_ready_i;
        w_data_o       = w_data_i;
        w_strb_o       = w_strb;
        w_last_o       = (r_cnt == 8'd0);
        if (w_w_hs && (r_cnt == 8'd0)) w_next = S_B;
      end
      S_B: begin
        b_ready_o = 1'b1;
        if (b_valid_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, beat counter and error accumulation; error pulses the cycle after retirement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_if        <= 1'b0;
      r_err       <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_req_hs) begin
        r_addr  <= rw_addr_i;
        r_len   <= rw_len_i;
        r_cnt   <= rw_len_i;
        r_size  <= rw_size_i;
        r_burst <= rw_burst_i;
        r_if    <= rw_if_i;
        r_err   <= 1'b0;
      end
      if (w_w_hs) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_r_hs) begin
        r_cnt <= r_cnt - 8'd1;
        if (w_r_beat_err) r_err <= 1'b1;
        if (r_last_i) r_err_pulse <= r_err | w_r_beat_err;
      end
      if (w_b_hs) begin
        r_err_pulse <= (b_resp_i != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_axi_master_bridge.sv
// Testbench for the cache-to-AXI master bridge: directed cases plus randomized transactions.
module tb_ysyx_22050133_axi_master_bridge;

  logic        clk;
  logic        rst;
  logic        rw_addr_valid_i, rw_addr_ready_o;
  logic [63:0] rw_addr_i;
  logic        rw_we_i, rw_if_i;
  logic [7:0]  rw_len_i;
  logic [2:0]  rw_size_i;
  logic [1:0]  rw_burst_i;
  logic        w_data_valid_i, w_data_ready_o;
  logic [63:0] w_data_i;
  logic        r_data_valid_o, r_data_ready_i;
  logic [63:0] r_data_o;
  logic        rw_err_o;
  logic        aw_valid_o, aw_ready_i;
  logic [63:0] aw_addr_o;
  logic [3:0]  aw_id_o;
  logic [7:0]  aw_len_o;
  logic [2:0]  aw_size_o;
  logic [1:0]  aw_burst_o;
  logic        w_valid_o, w_ready_i;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        w_last_o;
  logic        b_valid_i, b_ready_o;
  logic [1:0]  b_resp_i;
  logic        ar_valid_o, ar_ready_i;
  logic [63:0] ar_addr_o;
  logic [3:0]  ar_id_o;
  logic [7:0]  ar_len_o;
  logic [2:0]  ar_size_o;
  logic [1:0]  ar_burst_o;
  logic        r_valid_i, r_ready_o;
  logic [63:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic        r_last_i;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_22050133_axi_master_bridge dut (
    .clk(clk), .rst(rst),
    .rw_addr_valid_i(rw_addr_valid_i), .rw_addr_ready_o(rw_addr_ready_o),
    .rw_addr_i(rw_addr_i), .rw_we_i(rw_we_i), .rw_if_i(rw_if_i),
    .rw_len_i(rw_len_i), .rw_size_i(rw_size_i), .rw_burst_i(rw_burst_i),
    .w_data_valid_i(w_data_valid_i), .w_data_ready_o(w_data_ready_o), .w_data_i(w_data_i),
    .r_data_valid_o(r_data_valid_o), .r_data_ready_i(r_data_ready_i), .r_data_o(r_data_o),
    .rw_err_o(rw_err_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
    .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rw_addr_valid_i = 1'b0; rw_addr_i = '0; rw_we_i = 1'b0; rw_if_i = 1'b0;
    rw_len_i = '0; rw_size_i = '0; rw_burst_i = '0;
    w_data_valid_i = 1'b0; w_data_i = '0; r_data_ready_i = 1'b0;
    aw_ready_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0; b_resp_i = '0;
    ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0; r_last_i = 1'b0;
  endtask

  // Expected strobe: a single beat covers 2**size bytes shifted by the byte offset.
  function automatic logic [7:0] exp_strb(input logic [63:0] addr, input logic [7:0] len,
                                          input logic [2:0] size);
    int nbytes;
    int mask;
    if (len != 8'd0) return 8'hFF;
    nbytes = 2 ** int'(size);
    mask   = (2 ** nbytes) - 1;
    return 8'((mask * (2 ** int'(addr % 8))) % 256);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One full transaction from request to retirement.
  // err_beat: read beat carrying SLVERR (-1 none); last_beat: beat with rlast; abort_beat: reset in W.
  task automatic run_txn(input bit we, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit ifetch,
                         input int err_beat, input int last_beat, input logic [1:0] bresp,
                         input int bdelay, input int adly, input bit toggle, input int abort_beat);
    int  i;
    int  guard;
    int  dut_beats;
    bit  done;
    bit  exp_err;
    logic [7:0] strb;

    strb = exp_strb(addr, len, size);
    // request
    rw_addr_valid_i = 1'b1; rw_addr_i = addr; rw_we_i = we; rw_if_i = ifetch;
    rw_len_i = len; rw_size_i = size; rw_burst_i = burst;
    #1;
    chk("req_ready", {63'd0, rw_addr_ready_o}, 64'd1);
    next_cycle();
    // address phase; junk on the request and beat inputs must not leak
    for (int k = 0; k <= adly; k++) begin
      rw_addr_valid_i = 1'($urandom); rw_addr_i = rand64();
      aw_ready_i = we && (k == adly);
      ar_ready_i = !we && (k == adly);
      w_data_valid_i = 1'b1; w_ready_i = 1'b1; r_valid_i = 1'b1; r_data_ready_i = 1'b1;
      #1;
      chk("busy_ready", {63'd0, rw_addr_ready_o}, 64'd0);
      chk("aw_valid", {63'd0, aw_valid_o}, {63'd0, we});
      chk("ar_valid", {63'd0, ar_valid_o}, {63'd0, !we});
      chk("addr", we ? aw_addr_o : ar_addr_o, addr);
      chk("len", {56'd0, we ? aw_len_o : ar_len_o}, {56'd0, len});
      chk("size", {61'd0, we ? aw_size_o : ar_size_o}, {61'd0, size});
      chk("burst", {62'd0, we ? aw_burst_o : ar_burst_o}, {62'd0, burst});
      chk("id", {60'd0, we ? aw_id_o : ar_id_o}, (!we && ifetch) ? 64'd1 : 64'd0);
      chk("leak", {60'd0, w_valid_o, w_data_ready_o, r_data_valid_o, r_ready_o}, 64'd0);
      next_cycle();
    end
    idle_inputs();
    i = 0; guard = 0; done = 0; dut_beats = 0;
    if (we) begin
      while (!done && guard < 300) begin
        guard++;
        if (abort_beat >= 0 && i == abort_beat) begin
          w_data_valid_i = 1'b1; w_ready_i = 1'b0;
          #2 rst = 1'b1;
          #1;
          chk("rst_ready", {63'd0, rw_addr_ready_o}, 64'd1);
          chk("rst_valids", {59'd0, aw_valid_o, ar_valid_o, w_valid_o, b_ready_o, r_ready_o}, 64'd0);
          chk("rst_misc", {61'd0, w_data_ready_o, r_data_valid_o, rw_err_o}, 64'd0);
          @(negedge clk);
          rst = 1'b0;
          idle_inputs();
          return;
        end
        w_data_valid_i = toggle ? 1'b1 : ($urandom_range(3) != 0);
        w_ready_i      = toggle ? (guard % 2 == 1) : 1'($urandom);
        w_data_i       = toggle ? {8{8'((i + 1) * 17)}} : rand64();
        #1;
        chk("w_valid", {63'd0, w_valid_o}, {63'd0, w_data_valid_i});
        chk("w_data_ready", {63'd0, w_data_ready_o}, {63'd0, w_ready_i});
        chk("w_data", w_data_o, w_data_i);
        chk("w_last", {63'd0, w_last_o}, (i == int'(len)) ? 64'd1 : 64'd0);
        chk("w_strb", {56'd0, w_strb_o}, {56'd0, strb});
        chk("w_aw_low", {62'd0, aw_valid_o, b_ready_o}, 64'd0);
        if (w_data_valid_i && w_ready_i) begin
          i++;
          if (i > int'(len)) done = 1;
        end
        next_cycle();
      end
      if (!done) chk("w_timeout", 64'd0, 64'd1);
      // B phase; a new read request waits behind it
      for (int k = 0; k <= bdelay; k++) begin
        b_valid_i = (k == bdelay); b_resp_i = bresp;
        rw_addr_valid_i = 1'b1; rw_we_i = 1'b0; rw_addr_i = rand64();
        w_data_valid_i = 1'b1; w_ready_i = 1'b1;
        #1;
        chk("b_ready", {63'd0, b_ready_o}, 64'd1);
        chk("b_req_blocked", {61'd0, rw_addr_ready_o, ar_valid_o, aw_valid_o}, 64'd0);
        chk("b_w_quiet", {62'd0, w_valid_o, w_data_ready_o}, 64'd0);
        chk("b_err_early", {63'd0, rw_err_o}, 64'd0);
        next_cycle();
      end
      exp_err = (bresp != 2'b00);
    end else begin
      while (!done && guard < 300) begin
        guard++;
        r_valid_i      = ($urandom_range(3) != 0);
        r_data_ready_i = ($urandom_range(3) != 0);
        r_data_i       = rand64();
        r_last_i       = (i == last_beat);
        r_resp_i       = (i == err_beat) ? 2'd2 : 2'd0;
        #1;
        chk("r_valid", {63'd0, r_data_valid_o}, {63'd0, r_valid_i});
        chk("r_ready", {63'd0, r_ready_o}, {63'd0, r_data_ready_i});
        chk("r_data", r_data_o, r_data_i);
        chk("r_busy", {61'd0, rw_addr_ready_o, ar_valid_o, rw_err_o}, 64'd0);
        if (r_data_valid_o && r_data_ready_i) dut_beats++;
        if (r_valid_i && r_data_ready_i) begin
          i++;
          if (r_last_i) done = 1;
        end
        next_cycle();
      end
      if (!done) chk("r_timeout", 64'd0, 64'd1);
      chk("r_beats", 64'(dut_beats), 64'(last_beat + 1));
      exp_err = (err_beat >= 0 && err_beat <= last_beat) || (last_beat != int'(len));
    end
    // retirement
    idle_inputs();
    #1;
    chk("ret_ready", {63'd0, rw_addr_ready_o}, 64'd1);
    chk("ret_err", {63'd0, rw_err_o}, {63'd0, exp_err});
    chk("ret_valids", {62'd0, aw_valid_o, ar_valid_o}, 64'd0);
    next_cycle();
    #1;
    chk("err_pulse_end", {63'd0, rw_err_o}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_ready", {63'd0, rw_addr_ready_o}, 64'd1);
    chk("reset_valids", {59'd0, aw_valid_o, ar_valid_o, w_valid_o, b_ready_o, r_ready_o}, 64'd0);
    chk("reset_misc", {60'd0, w_data_ready_o, r_data_valid_o, rw_err_o, w_last_o}, 64'd0);
    chk("reset_fields", {48'd0, w_strb_o, ar_len_o}, 64'd0);
    chk("reset_addr", ar_addr_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // read burst, arready after 2 cycles
    run_txn(0, 64'h8000_0040, 8'd7, 3'd3, 2'd1, 0, -1, 7, 2'd0, 0, 2, 0, -1);
    // write burst with wready toggling
    run_txn(1, 64'h8000_0100, 8'd7, 3'd3, 2'd1, 0, -1, 0, 2'd0, 1, 1, 1, -1);
    // single halfword write at offset 3
    run_txn(1, 64'h8000_0003, 8'd0, 3'd1, 2'd1, 0, -1, 0, 2'd0, 0, 0, 0, -1);
    // writeback with slow B, then the refill read
    run_txn(1, 64'h8000_0200, 8'd3, 3'd3, 2'd1, 0, -1, 0, 2'd0, 5, 0, 0, -1);
    run_txn(0, 64'h8000_0200, 8'd3, 3'd3, 2'd1, 1, -1, 3, 2'd0, 0, 0, 0, -1);
    // SLVERR on read beat 3; early rlast on beat 5 (6th beat)
    run_txn(0, 64'h8000_0300, 8'd7, 3'd3, 2'd1, 0, 3, 7, 2'd0, 0, 1, 0, -1);
    run_txn(0, 64'h8000_0400, 8'd7, 3'd3, 2'd1, 0, -1, 5, 2'd0, 0, 0, 0, -1);
    // write error response
    run_txn(1, 64'h8000_0500, 8'd1, 3'd3, 2'd1, 0, -1, 0, 2'd2, 1, 0, 0, -1);
    // reset in the middle of a write burst, then a clean read
    run_txn(1, 64'h8000_0600, 8'd7, 3'd3, 2'd1, 0, -1, 0, 2'd0, 0, 0, 0, 3);
    run_txn(0, 64'h8000_0700, 8'd3, 3'd3, 2'd1, 1, -1, 3, 2'd0, 0, 0, 0, -1);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      bit          we;
      logic [7:0]  len;
      logic [2:0]  size;
      int          eb;
      int          lb;
      we   = 1'($urandom);
      len  = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom_range(15));
      size = 3'($urandom_range(3));
      eb   = ($urandom_range(5) == 0) ? int'($urandom_range(int'(len))) : -1;
      lb   = ($urandom_range(5) == 0) ? int'($urandom_range(int'(len))) : int'(len);
      run_txn(we, rand64(), len, size, 2'($urandom_range(2)), 1'($urandom), eb, lb,
              ($urandom_range(3) == 0) ? 2'd3 : 2'd0, int'($urandom_range(4)),
              int'($urandom_range(3)), 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
